// File: rtl/pcpi_div_multistep_if.sv
`default_nettype none
// ============================================================================
// Module   : pcpi_div_multistep_if
// Brief    : PCPI bus bundle between the CPU and the divide coprocessor.
// Revision : 1.0 - initial release
// ============================================================================
interface pcpi_div_multistep_if #(
  parameter int XLEN = 32
);
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic            pcpi_wait;
  logic            pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface
`default_nettype wire

// File: rtl/pcpi_div_multistep.sv
`default_nettype none
// ============================================================================
// Module   : pcpi_div_multistep
// Brief    : PCPI DIV/DIVU/REM/REMU coprocessor, STEPS restoring steps/cycle.
//            Optional macro PCPI_DIV_FASTPATH_EN skips RUN for trivial ops.
// Revision : 1.0 - initial release
// ============================================================================
module pcpi_div_multistep #(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  pcpi_div_multistep_if.slave  bus
);
  localparam int c_RUN_CYCLES = XLEN / STEPS;
  localparam int c_CNT_W      = $clog2(c_RUN_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic               r_signed;
  logic               r_rem;
  logic               r_outsign;
  logic [XLEN-1:0]    r_dividend;
  logic [2*XLEN-2:0]  r_divisor;
  logic [XLEN-1:0]    r_quotient;
  logic [XLEN-1:0]    r_mask;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_match;
  logic               w_unused_ok;
  logic               w_rs1_neg, w_rs2_neg;
  logic [XLEN-1:0]    w_rs1_abs, w_rs2_abs;
  logic               w_outsign;
  logic               w_fast;
  logic [XLEN-1:0]    w_q_init;
  logic [XLEN-1:0]    w_dvd;
  logic [2*XLEN-2:0]  w_dvs;
  logic [XLEN-1:0]    w_q;
  logic [XLEN-1:0]    w_m;
  logic [XLEN-1:0]    w_q_out, w_r_out;

  assign w_match = bus.pcpi_valid && !bus.pcpi_ready &&
                   (bus.pcpi_insn[6:0] == 7'b0110011) &&
                   (bus.pcpi_insn[31:25] == 7'b0000001) &&
                   bus.pcpi_insn[14];
  assign w_unused_ok = &{1'b0, bus.pcpi_insn[24:15], bus.pcpi_insn[11:7]};

  assign w_rs1_neg = r_signed && bus.pcpi_rs1[XLEN-1];
  assign w_rs2_neg = r_signed && bus.pcpi_rs2[XLEN-1];
  assign w_rs1_abs = w_rs1_neg ? -bus.pcpi_rs1 : bus.pcpi_rs1;
  assign w_rs2_abs = w_rs2_neg ? -bus.pcpi_rs2 : bus.pcpi_rs2;

  // A zero divisor must not flip the all-ones quotient of a signed DIV.
  assign w_outsign = (r_signed && !r_rem && (bus.pcpi_rs1[XLEN-1] != bus.pcpi_rs2[XLEN-1]) &&
                      (bus.pcpi_rs2 != '0)) ||
                     (r_signed && r_rem && bus.pcpi_rs1[XLEN-1]);

`ifdef PCPI_DIV_FASTPATH_EN
  assign w_fast = (bus.pcpi_rs2 == '0) || (w_rs1_abs < w_rs2_abs);
`else
  assign w_fast = 1'b0;
`endif
  // Skipped RUN must still leave the divide-by-zero quotient as all ones.
  assign w_q_init = (w_fast && (bus.pcpi_rs2 == '0)) ? '1 : '0;

  always_comb begin
    w_dvd = r_dividend;
    w_dvs = r_divisor;
    w_q   = r_quotient;
    w_m   = r_mask;
    for (int i = 0; i < STEPS; i++) begin
      if (w_dvs <= {{(XLEN-1){1'b0}}, w_dvd}) begin
        w_dvd = w_dvd - w_dvs[XLEN-1:0];
        w_q   = w_q | w_m;
      end
      w_dvs = w_dvs >> 1;
      w_m   = w_m >> 1;
    end
  end

  assign w_q_out = r_outsign ? -r_quotient : r_quotient;
  assign w_r_out = r_outsign ? -r_dividend : r_dividend;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_rd    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_match) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        bus.pcpi_wait = 1'b1;
        if (!bus.pcpi_valid)  w_state_nxt = S_IDLE;
        else if (w_fast)      w_state_nxt = S_DONE;
        else                  w_state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.pcpi_wait = 1'b1;
        if (!bus.pcpi_valid)          w_state_nxt = S_IDLE;
        else if (r_cnt == c_CNT_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = 1'b1;
        bus.pcpi_rd    = r_rem ? w_r_out : w_q_out;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_signed   <= 1'b0;
      r_rem      <= 1'b0;
      r_outsign  <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quotient <= '0;
      r_mask     <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_match) begin
            r_signed <= !bus.pcpi_insn[12];
            r_rem    <= bus.pcpi_insn[13];
          end
        end
        S_LOAD: begin
          r_dividend <= w_rs1_abs;
          r_divisor  <= {w_rs2_abs, {(XLEN-1){1'b0}}};
          r_quotient <= w_q_init;
          r_mask     <= {1'b1, {(XLEN-1){1'b0}}};
          r_outsign  <= w_outsign;
          r_cnt      <= '0;
        end
        S_RUN: begin
          r_dividend <= w_dvd;
          r_divisor  <= w_dvs;
          r_quotient <= w_q;
          r_mask     <= w_m;
          r_cnt      <= r_cnt + c_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pcpi_div_multistep.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcpi_div_multistep
// Brief    : Directed bench for three divider configs against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcpi_div_multistep;
  localparam int N = 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        valid [N];
  logic [31:0] insn  [N];
  logic [63:0] rs1   [N];
  logic [63:0] rs2   [N];
  logic        ready [N];
  logic        wr    [N];
  logic        busy  [N];
  logic [63:0] rd    [N];

  int vectors = 0;
  int errors  = 0;

  pcpi_div_multistep_if #(.XLEN(32)) bus0 ();
  pcpi_div_multistep_if #(.XLEN(32)) bus1 ();
  pcpi_div_multistep_if #(.XLEN(64)) bus2 ();

  assign bus0.pcpi_valid = valid[0];
  assign bus0.pcpi_insn  = insn[0];
  assign bus0.pcpi_rs1   = rs1[0][31:0];
  assign bus0.pcpi_rs2   = rs2[0][31:0];
  assign ready[0] = bus0.pcpi_ready;
  assign wr[0]    = bus0.pcpi_wr;
  assign busy[0]  = bus0.pcpi_wait;
  assign rd[0]    = {32'h0, bus0.pcpi_rd};

  assign bus1.pcpi_valid = valid[1];
  assign bus1.pcpi_insn  = insn[1];
  assign bus1.pcpi_rs1   = rs1[1][31:0];
  assign bus1.pcpi_rs2   = rs2[1][31:0];
  assign ready[1] = bus1.pcpi_ready;
  assign wr[1]    = bus1.pcpi_wr;
  assign busy[1]  = bus1.pcpi_wait;
  assign rd[1]    = {32'h0, bus1.pcpi_rd};

  assign bus2.pcpi_valid = valid[2];
  assign bus2.pcpi_insn  = insn[2];
  assign bus2.pcpi_rs1   = rs1[2];
  assign bus2.pcpi_rs2   = rs2[2];
  assign ready[2] = bus2.pcpi_ready;
  assign wr[2]    = bus2.pcpi_wr;
  assign busy[2]  = bus2.pcpi_wait;
  assign rd[2]    = bus2.pcpi_rd;

  pcpi_div_multistep #(.XLEN(32), .STEPS(1)) u_dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  pcpi_div_multistep #(.XLEN(32), .STEPS(4)) u_dut1 (.clk(clk), .resetn(resetn), .bus(bus1));
  pcpi_div_multistep #(.XLEN(64), .STEPS(4)) u_dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

  function automatic int xl_of(int d);
    return (d == 2) ? 64 : 32;
  endfunction

  function automatic int steps_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [63:0] mask_of(int xl);
    return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit is_match(logic v, logic [31:0] w);
    return v && (w[6:0] == 7'b0110011) && (w[31:25] == 7'b0000001) && w[14];
  endfunction

  // RISC-V M-extension result, computed with native signed/unsigned arithmetic.
  function automatic logic [63:0] model_res(int xl, logic [2:0] f3, logic [63:0] a, logic [63:0] b);
    logic [63:0] m, ua, ub, r;
    longint sa, sb;
    bit ovf;
    m  = mask_of(xl);
    ua = a & m;
    ub = b & m;
    if (xl == 32) begin
      sa = longint'($signed(a[31:0]));
      sb = longint'($signed(b[31:0]));
    end else begin
      sa = $signed(a);
      sb = $signed(b);
    end
    ovf = (xl == 64) && (a == 64'h8000_0000_0000_0000) && (sb == -1);
    case (f3)
      3'b100:  r = (ub == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf ? a : 64'(sa / sb));
      3'b101:  r = (ub == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ua / ub;
      3'b110:  r = (ub == 0) ? 64'(sa) : (ovf ? 64'h0 : 64'(sa % sb));
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return r & m;
  endfunction

  function automatic int model_lat(int d, logic [2:0] f3, logic [63:0] a, logic [63:0] b);
    int xl;
    logic [63:0] m, ua, ub, ma, mb;
    xl = xl_of(d);
    m  = mask_of(xl);
    ua = a & m;
    ub = b & m;
    ma = (!f3[0] && ua[xl-1]) ? ((-ua) & m) : ua;
    mb = (!f3[0] && ub[xl-1]) ? ((-ub) & m) : ub;
`ifdef PCPI_DIV_FASTPATH_EN
    if ((ub == 0) || (ma < mb)) return 2;
`else
    if (ma > mb) return xl / steps_of(d) + 2;
`endif
    return xl / steps_of(d) + 2;
  endfunction

  // Transaction model: age is the cycle number since accept (1 = LOAD).
  bit          m_act [N];
  int          m_age [N];
  int          m_lat [N];
  logic [63:0] m_exp [N];

  always @(posedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (!resetn) begin
        m_act[d] <= 1'b0;
      end else if (m_act[d]) begin
        if ((m_age[d] == m_lat[d]) || !valid[d]) m_act[d] <= 1'b0;
        else                                     m_age[d] <= m_age[d] + 1;
      end else if (is_match(valid[d], insn[d])) begin
        m_act[d] <= 1'b1;
        m_age[d] <= 1;
        m_lat[d] <= model_lat(d, insn[d][14:12], rs1[d], rs2[d]);
        m_exp[d] <= model_res(xl_of(d), insn[d][14:12], rs1[d], rs2[d]);
      end
    end
  end

  task automatic chk(string name, int d, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got 0x%0h, want 0x%0h", name, d, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      logic e_rdy, e_wait;
      e_rdy  = m_act[d] && (m_age[d] == m_lat[d]);
      e_wait = m_act[d] && (m_age[d] <  m_lat[d]);
      chk("model_ready", d, 64'(ready[d]), 64'(e_rdy));
      chk("model_wr",    d, 64'(wr[d]),    64'(e_rdy));
      chk("model_wait",  d, 64'(busy[d]),  64'(e_wait));
      chk("model_rd",    d, rd[d], e_rdy ? m_exp[d] : 64'h0);
    end
  end

  function automatic logic [31:0] mk_insn(logic [2:0] f3, logic [6:0] f7);
    return {f7, 10'h0, f3, 5'h0, 7'b0110011};
  endfunction

  task automatic start_op(int d, logic [2:0] f3, logic [63:0] a, logic [63:0] b);
    @(negedge clk);
    insn[d]  = mk_insn(f3, 7'b0000001);
    rs1[d]   = a;
    rs2[d]   = b;
    valid[d] = 1'b1;
  endtask

  task automatic wait_ready(int d, output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while ((n < 200) && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (ready[d] === 1'b1) got = 1'b1;
    end
  endtask

  task automatic run_op(string name, int d, logic [2:0] f3, logic [63:0] a, logic [63:0] b,
                        logic [63:0] exp_rd, int exp_lat);
    int n;
    bit got;
    start_op(d, f3, a, b);
    wait_ready(d, n, got);
    chk({name, "_lat"}, d, 64'(n), 64'(exp_lat));
    chk({name, "_rd"},  d, rd[d], exp_rd);
    chk({name, "_wr"},  d, 64'(wr[d]), 64'd1);
    @(negedge clk);
    valid[d] = 1'b0;
  endtask

`ifdef PCPI_DIV_FASTPATH_EN
  localparam int LZ0 = 2;
  localparam int LZ2 = 2;
`else
  localparam int LZ0 = 34;
  localparam int LZ2 = 18;
`endif

  localparam logic [63:0] M100 = 64'hFFFF_FFFF_FFFF_FF9C;
  localparam logic [63:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] M5   = 64'hFFFF_FFFF_FFFF_FFFB;

  initial begin
    int n, cnt;
    bit got;
    resetn = 1'b0;
    for (int d = 0; d < N; d++) begin
      valid[d] = 1'b0;
      insn[d]  = 32'h0;
      rs1[d]   = 64'h0;
      rs2[d]   = 64'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      chk("reset_wait",  d, 64'(busy[d]),  64'd0);
      chk("reset_ready", d, 64'(ready[d]), 64'd0);
      chk("reset_rd",    d, rd[d], 64'h0);
    end
    resetn = 1'b1;

    run_op("divu_100_7",  0, 3'b101, 64'd100, 64'd7, 64'd14, 34);
    run_op("remu_100_7",  0, 3'b111, 64'd100, 64'd7, 64'd2,  34);
    run_op("div_m100_7",  0, 3'b100, M100, 64'd7, 64'hFFFF_FFF2, 34);
    run_op("rem_m100_7",  0, 3'b110, M100, 64'd7, 64'hFFFF_FFFE, 34);
    run_op("rem_100_m7",  0, 3'b110, 64'd100, M7, 64'd2, 34);
    run_op("divu_by0",    0, 3'b101, 64'h1234, 64'd0, 64'hFFFF_FFFF, LZ0);
    run_op("div_by0",     0, 3'b100, 64'h1234, 64'd0, 64'hFFFF_FFFF, LZ0);
    run_op("rem_by0",     0, 3'b110, 64'h1234, 64'd0, 64'h1234, LZ0);
    run_op("rem_neg_by0", 0, 3'b110, M100, 64'd0, 64'hFFFF_FF9C, LZ0);
    run_op("div_ovf",     0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 34);
    run_op("rem_ovf",     0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 34);
    run_op("divu_small",  0, 3'b101, 64'd5, 64'd9, 64'd0, LZ0);
    run_op("rem_small",   0, 3'b110, M5, 64'd9, 64'hFFFF_FFFB, LZ0);

    run_op("s4_divu",     1, 3'b101, 64'd100, 64'd7, 64'd14, 10);
    run_op("s4_div",      1, 3'b100, M100, 64'd7, 64'hFFFF_FFF2, 10);
    run_op("s4_rem_ovf",  1, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 10);

    run_op("x64_divu",    2, 3'b101, 64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 18);
    run_op("x64_div_ovf", 2, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 18);
    run_op("x64_rem_ovf", 2, 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 18);
    run_op("x64_div_neg", 2, 3'b100, M100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 18);
    run_op("x64_remu_0",  2, 3'b111, 64'h1234, 64'd0, 64'h1234, LZ2);

    // Abort: valid drops during RUN cycle 5 (overall cycle 6).
    start_op(0, 3'b101, 64'd1000, 64'd3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wait",  0, 64'(busy[0]),  64'd0);
    chk("abort_ready", 0, 64'(ready[0]), 64'd0);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready[0] === 1'b1) cnt++;
    end
    chk("abort_no_ready", 0, 64'(cnt), 64'd0);
    run_op("after_abort", 0, 3'b101, 64'd9, 64'd3, 64'd3, 34);

    // Reset mid-RUN.
    start_op(0, 3'b101, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_wait",  0, 64'(busy[0]),  64'd0);
    chk("rst_ready", 0, 64'(ready[0]), 64'd0);
    chk("rst_rd",    0, rd[0], 64'h0);
    @(negedge clk);
    resetn   = 1'b1;
    valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    run_op("after_rst", 0, 3'b111, 64'd100, 64'd7, 64'd2, 34);

    // Non-matching funct3 with matching opcode/funct7.
    @(negedge clk);
    insn[1]  = mk_insn(3'b000, 7'b0000001);
    rs1[1]   = 64'd100;
    rs2[1]   = 64'd7;
    valid[1] = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (busy[1] !== 1'b0) cnt++;
    end
    chk("nomatch_wait", 1, 64'(cnt), 64'd0);
    @(negedge clk);
    valid[1] = 1'b0;

    // Valid held past DONE retriggers after one idle cycle.
    start_op(1, 3'b101, 64'd100, 64'd7);
    wait_ready(1, n, got);
    chk("retrig_first_lat", 1, 64'(n), 64'd10);
    wait_ready(1, n, got);
    chk("retrig_second_lat", 1, 64'(n), 64'd11);
    chk("retrig_rd", 1, rd[1], 64'd14);
    @(negedge clk);
    valid[1] = 1'b0;

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
